// File: rtl/mem_lsu.sv
// Memory-access stage: passes non-memory ops straight through and serialises
// loads/stores into byte transfers on an 8-bit req/ack bus, stalling until done.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  output logic [4:0]  mem_wd,
  output logic [31:0] mem_data,
  output logic        mem_wreg,
  output logic        stall_req,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  logic [1:0]  state_r;
  logic [1:0]  idx_r;
  logic [31:0] buf_r;
  logic        is_load_s;
  logic        is_store_s;
  logic        is_mem_s;
  logic [1:0]  last_idx_s;

  // Index of the final byte of the access (transfer size minus one).
  function automatic logic [1:0] last_idx(input logic [3:0] op);
    case (op)
      OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
      OP_LW, OP_SW:         last_idx = 2'd3;
      default:              last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [3:0] op, input logic [31:0] data);
    case (op)
      OP_LB:   extend_load = {{24{data[7]}}, data[7:0]};
      OP_LBU:  extend_load = {24'd0, data[7:0]};
      OP_LH:   extend_load = {{16{data[15]}}, data[15:0]};
      OP_LHU:  extend_load = {16'd0, data[15:0]};
      OP_LW:   extend_load = data;
      default: extend_load = 32'd0;
    endcase
  endfunction

  assign is_load_s  = (ex_memop >= OP_LB) && (ex_memop <= OP_LHU);
  assign is_store_s = (ex_memop >= OP_SB) && (ex_memop <= OP_SW);
  assign is_mem_s   = is_load_s || is_store_s;
  assign last_idx_s = last_idx(ex_memop);

  // Access sequencer: byte index and load assembly buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      buf_r   <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (is_mem_s) begin
            state_r <= ST_BUSY;
            idx_r   <= 2'd0;
            buf_r   <= 32'd0;
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            if (is_load_s) begin
              buf_r[{idx_r, 3'b000} +: 8] <= bus_rdata;
            end
            if (idx_r == last_idx_s) begin
              state_r <= ST_DONE;
            end else begin
              idx_r <= idx_r + 2'd1;
            end
          end
        end
        ST_DONE: state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output decode; reset gates everything to zero in the same cycle.
  always_comb begin
    mem_wd    = 5'd0;
    mem_data  = 32'd0;
    mem_wreg  = 1'b0;
    stall_req = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 8'd0;
    if (rst) begin
      stall_req = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_wd = ex_wd;
          if (is_mem_s) begin
            stall_req = 1'b1;
          end else begin
            mem_wreg = ex_wreg;
            mem_data = ex_wdata;
          end
        end
        ST_BUSY: begin
          mem_wd    = ex_wd;
          stall_req = 1'b1;
          bus_req   = 1'b1;
          bus_we    = is_store_s;
          bus_addr  = ex_addr + {30'd0, idx_r};
          bus_wdata = ex_sdata[{idx_r, 3'b000} +: 8];
        end
        ST_DONE: begin
          mem_wd = ex_wd;
          if (is_load_s) begin
            mem_wreg = ex_wreg;
            mem_data = extend_load(ex_memop, buf_r);
          end else begin
            mem_wreg = 1'b0;
            mem_data = 32'd0;
          end
        end
        default: stall_req = 1'b0;
      endcase
    end
  end

endmodule
